// File: rtl/fpu_mant_pkg.sv
// Shared types and sizing for the serial mantissa magnitude unit.
package fpu_mant_pkg;

   localparam int unsigned WIDTH_DEF = 28;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Nibbles per operand for a given mantissa width.
   function automatic int unsigned nib_count(input int unsigned width);
      return width / 4;
   endfunction

endpackage

// File: rtl/fpu_nib_neg.sv
// One nibble of a serial two's-complement negate, carrying a sticky "seen a one" flag.
module fpu_nib_neg (
   input  logic [3:0] i_nib,
   input  logic       i_sticky,
   output logic [3:0] o_nib,
   output logic       o_sticky
);

   logic [3:0] w_lower;

   // Bit i flips once any lower bit (or an earlier nibble) was a one.
   always_comb begin
      w_lower[0] = i_sticky;
      for (int i = 1; i < 4; i++) begin
         w_lower[i] = w_lower[i-1] | i_nib[i-1];
      end
      o_nib    = i_nib ^ w_lower;
      o_sticky = i_sticky | (|i_nib);
   end

endmodule

// File: rtl/fpu_mant_abs_serial.sv
// Serial absolute value of a two's-complement mantissa, one nibble per cycle, LSB first.
module fpu_mant_abs_serial
   import fpu_mant_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_mag,
   output logic             o_neg,
   output logic             o_zero
);

   localparam int unsigned NIB   = nib_count(WIDTH);
   localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sticky;
   logic [WIDTH-1:0]   r_mag;
   logic               r_neg;
   logic               r_zero;
   logic               w_last;
   logic [3:0]         w_nib_in;
   logic [3:0]         w_nib_neg;
   logic [3:0]         w_nib_res;
   logic               w_sticky_nxt;
   logic               w_ready;
   logic               w_valid;

   assign w_last = (r_cnt == CNT_W'(NIB - 1));

   always_comb begin
      w_nib_in = 4'h0;
      for (int k = 0; k < NIB; k++) begin
         if (r_cnt == CNT_W'(k)) w_nib_in = r_mag[4*k +: 4];
      end
   end

   fpu_nib_neg u_nib_neg (
      .i_nib    (w_nib_in),
      .i_sticky (r_sticky),
      .o_nib    (w_nib_neg),
      .o_sticky (w_sticky_nxt)
   );

   assign w_nib_res = r_neg ? w_nib_neg : w_nib_in;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_valid) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
         ST_DONE: if (i_ready) w_state_nxt = ST_IDLE;
         default:              w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      w_valid = 1'b0;
      case (r_state)
         ST_IDLE: w_ready = 1'b1;
         ST_DONE: w_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand is captured into the result register and rewritten in place nibble by nibble.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mag    <= '0;
         r_neg    <= 1'b0;
         r_zero   <= 1'b0;
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_valid) begin
                  r_mag    <= i_data;
                  r_neg    <= i_data[WIDTH-1];
                  r_zero   <= (i_data == '0);
                  r_cnt    <= '0;
                  r_sticky <= 1'b0;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NIB; k++) begin
                  if (r_cnt == CNT_W'(k)) r_mag[4*k +: 4] <= w_nib_res;
               end
               r_sticky <= w_sticky_nxt;
               r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_ready = w_ready;
   assign o_valid = w_valid;
   assign o_mag   = r_mag;
   assign o_neg   = r_neg;
   assign o_zero  = r_zero;

endmodule

// File: tb/tb_fpu_mant_abs_serial.sv
// Randomized self-checking bench for fpu_mant_abs_serial against an arithmetic abs() model.
module tb_fpu_mant_abs_serial;

   localparam int unsigned W   = 28;
   localparam int unsigned NIB = W / 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          in_ready;
   logic [W-1:0]  mag;
   logic          neg;
   logic          zero;

   int n_checks;
   int n_fail;

   fpu_mant_abs_serial #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid),
      .o_ready (out_ready),
      .i_data  (in_data),
      .o_valid (out_valid),
      .i_ready (in_ready),
      .o_mag   (mag),
      .o_neg   (neg),
      .o_zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one operand, wait for its result, hold i_ready low for hold cycles, then retire it.
   // If keep is set, i_valid stays high with next_data after the accept edge.
   task automatic do_op(input logic [W-1:0] x, input int hold,
                        input bit keep, input logic [W-1:0] next_data);
      logic [W-1:0] exp_mag;
      int           edges;
      exp_mag = x[W-1] ? W'(-x) : x;
      in_valid = 1'b1;
      in_data  = x;
      check("ready_idle", 64'(out_ready), 64'd1);
      step();
      edges = 1;
      if (keep) in_data = next_data;
      else      in_valid = 1'b0;
      check("ready_run", 64'(out_ready), 64'd0);
      while (!out_valid && edges < 40) begin
         step();
         edges++;
      end
      check("latency", 64'(edges), 64'(NIB + 1));
      for (int h = 0; h <= hold; h++) begin
         check("valid", 64'(out_valid), 64'd1);
         check("mag",   64'(mag),  64'(exp_mag));
         check("neg",   64'(neg),  64'(x[W-1]));
         check("zero",  64'(zero), 64'(x == '0));
         if (h < hold) step();
      end
      check("ready_done", 64'(out_ready), 64'd0);
      in_ready = 1'b1;
      step();
      in_ready = 1'b0;
      check("valid_drop", 64'(out_valid), 64'd0);
   endtask

   initial begin
      int seen_valid;
      logic [W-1:0] r;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_ready = 1'b0;
      @(negedge clk);
      step();
      rst = 1'b0;
      check("rst_ready", 64'(out_ready), 64'd1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_mag",   64'(mag),       64'd0);
      check("rst_neg",   64'(neg),       64'd0);
      check("rst_zero",  64'(zero),      64'd0);

      do_op(28'h0000005, 0, 1'b0, '0);
      do_op(28'hFFFFFFB, 0, 1'b0, '0);
      do_op(28'h8000000, 0, 1'b0, '0);
      do_op(28'h0000000, 0, 1'b0, '0);

      // Held result under back-pressure; a second operand presented during RUN waits for IDLE.
      do_op(28'hFFF0100, 3, 1'b1, 28'h0000123);
      do_op(28'h0000123, 0, 1'b0, '0);

      // Reset in the middle of RUN drops the operation.
      in_valid = 1'b1;
      in_data  = 28'h1234567;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_ready", 64'(out_ready), 64'd1);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_mag",   64'(mag),       64'd0);
      check("mid_rst_neg",   64'(neg),       64'd0);
      seen_valid = 0;
      for (int i = 0; i < NIB + 3; i++) begin
         if (out_valid) seen_valid = 1;
         step();
      end
      check("mid_rst_no_valid", 64'(seen_valid), 64'd0);
      do_op(28'hFFFFFFF, 0, 1'b0, '0);

      // Random stream, back to back with occasional back-pressure.
      for (int t = 0; t < 60; t++) begin
         r = W'($urandom);
         if (t % 17 == 5) r = 28'h8000000;
         if (t % 19 == 7) r = '0;
         do_op(r, int'($urandom_range(0, 2)), 1'b0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
